// File: rtl/afifo_clear_pkg.sv
// Shared definitions for the AFIFO synchronous-clear initiator:
// handshake state encoding and the default cycle-counter width.
package afifo_clear_pkg;

    localparam int CLR_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ASSERT    = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_NACK = 2'd3
    } clr_state_e;

endpackage

// File: rtl/afifo_clear_ctrl.sv
// Initiator side of the AFIFO clear handshake: turns clear commands into a
// held request level, runs req/ack four-phase with timeouts, gates FIFO access.
module afifo_clear_ctrl
    import afifo_clear_pkg::*;
#(
    parameter int MIN_HOLD_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_WIDTH       = CLR_CNT_WIDTH
) (
    input  logic main_clk,
    input  logic main_rst_n,
    input  logic clear_start,
    input  logic err_clr,
    input  logic sync_clear_ack,
    output logic sync_clear_req,
    output logic clear_busy,
    output logic block_access,
    output logic clear_pending,
    output logic clear_done,
    output logic clear_timeout
);

    localparam logic [CNT_WIDTH-1:0] MIN_C   = CNT_WIDTH'(MIN_HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TO_C    = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    clr_state_e           r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_start;
    logic                 r_fail, w_fail_nxt;
    logic                 r_req, w_req_nxt;
    logic                 r_busy;
    logic                 r_pend, w_pend_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic                 w_to_set;

    // Command capture; the FSM acts on the registered command one cycle later.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            r_start <= 1'b0;
        end else begin
            r_start <= clear_start;
        end
    end

    // Next-state, counter, request and status decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_pend_nxt  = r_pend;
        w_fail_nxt  = r_fail;
        w_done_nxt  = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_nxt = 1'b0;
                // A stale ack from a previous clear must drain before a new request.
                if ((r_start || r_pend) && !sync_clear_ack) begin
                    w_state_nxt = ST_ASSERT;
                    w_req_nxt   = 1'b1;
                    w_pend_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_cnt_nxt   = CNT_ONE;
                end else if (r_start) begin
                    w_pend_nxt = 1'b1;
                end else begin
                    w_pend_nxt = r_pend;
                end
            end
            ST_ASSERT: begin
                w_pend_nxt = r_pend | r_start;
                w_cnt_nxt  = r_cnt + CNT_ONE;
                if (r_cnt == MIN_C) begin
                    if (sync_clear_ack) begin
                        w_state_nxt = ST_WAIT_NACK;
                        w_req_nxt   = 1'b0;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_WAIT_ACK;
                    end
                end else begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_WAIT_ACK: begin
                w_pend_nxt = r_pend | r_start;
                w_cnt_nxt  = r_cnt + CNT_ONE;
                if (sync_clear_ack) begin
                    w_state_nxt = ST_WAIT_NACK;
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = CNT_ONE;
                end else if (r_cnt == TO_C) begin
                    w_state_nxt = ST_WAIT_NACK;
                    w_req_nxt   = 1'b0;
                    w_fail_nxt  = 1'b1;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_NACK: begin
                w_pend_nxt = r_pend | r_start;
                w_req_nxt  = 1'b0;
                w_cnt_nxt  = r_cnt + CNT_ONE;
                if (!sync_clear_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_to_set    = r_fail;
                    w_done_nxt  = ~r_fail;
                end else if (r_cnt == TO_C) begin
                    w_state_nxt = ST_IDLE;
                    w_fail_nxt  = 1'b1;
                    w_to_set    = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_NACK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase

        // Setting the sticky flag takes priority over clearing it.
        if (w_to_set) begin
            w_timeout_nxt = 1'b1;
        end else if (err_clr) begin
            w_timeout_nxt = 1'b0;
        end else begin
            w_timeout_nxt = r_timeout;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_fail    <= 1'b0;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_pend    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fail    <= w_fail_nxt;
            r_req     <= w_req_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_pend    <= w_pend_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign sync_clear_req = r_req;
    assign clear_busy     = r_busy;
    assign block_access   = r_busy;
    assign clear_pending  = r_pend;
    assign clear_done     = r_done;
    assign clear_timeout  = r_timeout;

endmodule
